dmem_arbiter: RTL and testbench

- Two-port request arbiter and access sequencer in front of the byte-array data memory (64 bytes, 64-bit little-endian word access).
- Port 0 is the pipeline load/store unit; port 1 is the debug/loader port that preloads and inspects data memory.
- Performs round-robin arbitration, alignment and range checking, and one-access-at-a-time sequencing.
- Returns read data over a registered valid-only response channel.

---
 rtl/dmem_arbiter_pkg.sv | 26 ++
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter_rr_arbiter2.sv | 23 ++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// State encoding, memory geometry and the address legality check.
package dmem_arb_pkg;

    localparam int MEM_BYTES  = 64;
    localparam int WORD_BYTES = 8;
    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Word aligned and the whole word lies inside the memory.
    function automatic logic addr_legal(
        input logic [ADDR_W-1:0] addr,
        input int unsigned       mem_bytes
    );
        logic [ADDR_W-1:0] last_word;
        last_word = ADDR_W'(mem_bytes) - ADDR_W'(WORD_BYTES);
        return (addr[2:0] == 3'b000) && (addr <= last_word);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter.
// Request side is valid/ready; response side is a valid-only pulse.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();

    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_err,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_err,
        output rsp_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant logic.
// On a tie the requester that did not win last time is granted.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    // One-hot grant; nothing granted while disabled.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and one-at-a-time sequencer for the data memory.
// Port 0 is the load/store unit, port 1 the debug/loader port.
module dmem_arbiter #(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Write_Data,
    input  logic [DATA_W-1:0] Read_Data
);

    import dmem_arb_pkg::*;

    state_t            state;
    state_t            state_d;
    logic              last_grant;
    logic              lat_port;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic [1:0]        grant;
    logic              arb_en;
    logic              accept;
    logic              sel;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              legal;

    assign arb_en    = (state == IDLE) && !reset;
    assign accept    = |grant;
    assign sel       = grant[1];
    assign req_write = sel ? p1.req_write : p0.req_write;
    assign req_addr  = sel ? p1.req_addr  : p0.req_addr;
    assign req_wdata = sel ? p1.req_wdata : p0.req_wdata;
    assign legal     = addr_legal(req_addr, MEM_BYTES);

    rr_arbiter2 u_rr (
        .req        ({p1.req_valid, p0.req_valid}),
        .last_grant (last_grant),
        .enable     (arb_en),
        .grant      (grant)
    );

    // Sequence: accept in IDLE, one memory cycle, one response cycle.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (accept) state_d = legal ? ACCESS : RESP;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Latch the accepted request and capture load data.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            lat_port   <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (accept) begin
                last_grant <= sel;
                lat_port   <= sel;
                lat_write  <= req_write;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                err_q      <= !legal;
                rdata_q    <= '0;
            end
            if (state == ACCESS && !lat_write) begin
                rdata_q <= Read_Data;
            end
        end
    end

    // Memory side is only driven during the access cycle.
    always_comb begin
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        Mem_Addr   = '0;
        Write_Data = '0;
        if (!reset && state == ACCESS) begin
            Mem_Addr = lat_addr;
            MemWrite = lat_write;
            MemRead  = !lat_write;
            if (lat_write) Write_Data = lat_wdata;
        end
    end

    // Handshake and response pulse for the owning port.
    always_comb begin
        p0.req_ready = grant[0];
        p1.req_ready = grant[1];
        p0.rsp_valid = 1'b0;
        p0.rsp_err   = 1'b0;
        p0.rsp_rdata = '0;
        p1.rsp_valid = 1'b0;
        p1.rsp_err   = 1'b0;
        p1.rsp_rdata = '0;
        if (!reset && state == RESP) begin
            if (lat_port) begin
                p1.rsp_valid = 1'b1;
                p1.rsp_err   = err_q;
                p1.rsp_rdata = rdata_q;
            end else begin
                p0.rsp_valid = 1'b1;
                p0.rsp_err   = err_q;
                p0.rsp_rdata = rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic.
// A word-level memory and latency model predicts every output each cycle.
module tb_dmem_arbiter;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic [63:0] Read_Data;

    dmem_arbiter_if p0 ();
    dmem_arbiter_if p1 ();

    dmem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .p0         (p0),
        .p1         (p1),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Mem_Addr   (Mem_Addr),
        .Write_Data (Write_Data),
        .Read_Data  (Read_Data)
    );

    always #5 clk = ~clk;

    // Byte-array data memory seen by the DUT.
    logic [7:0] mem [64] = '{default: 8'h00};

    always_comb begin
        Read_Data = '0;
        if (Mem_Addr <= 64'd56)
            for (int i = 0; i < 8; i++)
                Read_Data[i*8 +: 8] = mem[int'(Mem_Addr) + i];
    end

    always @(posedge clk) begin
        if (MemWrite && Mem_Addr <= 64'd56)
            for (int i = 0; i < 8; i++)
                mem[int'(Mem_Addr) + i] <= Write_Data[i*8 +: 8];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Reference model state: one outstanding op, word-indexed memory.
    logic [63:0] ref_mem [8] = '{default: 64'h0};
    int          cyc        = 0;
    bit          have_pend  = 0;
    int          pend_port, pend_acc, pend_rsp;
    bit          pend_write, pend_err;
    logic [63:0] pend_addr, pend_wdata, pend_data;
    int          last_win   = 1;

    // Observed events for the directed checks.
    bit          acc0 = 0;
    bit          acc1 = 0;
    int          acc_cnt [2] = '{0, 0};
    int          acc_cyc [2] = '{0, 0};
    int          rsp_cnt [2] = '{0, 0};
    int          rsp_cyc [2] = '{0, 0};
    logic [63:0] rsp_data [2];
    bit          rsp_err [2];
    int          mw_cnt  = 0;
    logic [63:0] mw_addr = 0;
    int          grant_log [$];
    int          acc_log [$];

    // Predict and compare all outputs mid-cycle.
    always @(negedge clk) begin
        bit          idle;
        bit          v0, v1, lw, legal;
        int          win;
        logic [1:0]  e_rdy, e_rv;
        logic        e_mw, e_mr, e_err;
        logic [63:0] e_ma, e_wd, e_rd, la, ld;

        cyc++;
        e_rdy = 0; e_rv = 0; e_mw = 0; e_mr = 0; e_err = 0;
        e_ma = 0; e_wd = 0; e_rd = 0;
        if (reset) begin
            have_pend = 0;
            last_win  = 1;
        end else begin
            idle = !have_pend;
            if (have_pend && cyc == pend_acc) begin
                e_ma = pend_addr;
                if (pend_write) begin
                    e_mw = 1;
                    e_wd = pend_wdata;
                    ref_mem[int'(pend_addr / 8)] = pend_wdata;
                end else begin
                    e_mr = 1;
                    pend_data = ref_mem[int'(pend_addr / 8)];
                end
            end
            if (have_pend && cyc == pend_rsp) begin
                e_rv[pend_port] = 1;
                e_err = pend_err;
                e_rd  = pend_data;
                have_pend = 0;
            end
            if (idle) begin
                v0 = p0.req_valid;
                v1 = p1.req_valid;
                win = -1;
                if (v0 && v1) win = 1 - last_win;
                else if (v0)  win = 0;
                else if (v1)  win = 1;
                if (win >= 0) begin
                    lw = (win == 1) ? p1.req_write : p0.req_write;
                    la = (win == 1) ? p1.req_addr  : p0.req_addr;
                    ld = (win == 1) ? p1.req_wdata : p0.req_wdata;
                    legal = (la % 8 == 0) && (la <= 64'd56);
                    e_rdy[win] = 1;
                    have_pend  = 1;
                    pend_port  = win;
                    pend_write = lw;
                    pend_addr  = la;
                    pend_wdata = ld;
                    pend_err   = !legal;
                    pend_data  = 0;
                    pend_acc   = legal ? cyc + 1 : -1;
                    pend_rsp   = cyc + (legal ? 2 : 1);
                    last_win   = win;
                end
            end
        end

        chk("ready", 64'({p1.req_ready, p0.req_ready}), 64'(e_rdy));
        chk("mem_we_re", 64'({MemWrite, MemRead}), 64'({e_mw, e_mr}));
        chk("mem_addr", Mem_Addr, e_ma);
        if (!e_mr) chk("mem_wdata", Write_Data, e_wd);
        chk("rsp_valid", 64'({p1.rsp_valid, p0.rsp_valid}), 64'(e_rv));
        chk("rsp0_err", 64'(p0.rsp_err), 64'(e_rv[0] & e_err));
        chk("rsp1_err", 64'(p1.rsp_err), 64'(e_rv[1] & e_err));
        chk("rsp0_rdata", p0.rsp_rdata, e_rv[0] ? e_rd : 64'h0);
        chk("rsp1_rdata", p1.rsp_rdata, e_rv[1] ? e_rd : 64'h0);

        acc0 = p0.req_valid && p0.req_ready;
        acc1 = p1.req_valid && p1.req_ready;
        if (acc0) begin
            acc_cnt[0]++; acc_cyc[0] = cyc;
            grant_log.push_back(0); acc_log.push_back(cyc);
        end
        if (acc1) begin
            acc_cnt[1]++; acc_cyc[1] = cyc;
            grant_log.push_back(1); acc_log.push_back(cyc);
        end
        if (p0.rsp_valid) begin
            rsp_cnt[0]++; rsp_cyc[0] = cyc;
            rsp_data[0] = p0.rsp_rdata; rsp_err[0] = p0.rsp_err;
        end
        if (p1.rsp_valid) begin
            rsp_cnt[1]++; rsp_cyc[1] = cyc;
            rsp_data[1] = p1.rsp_rdata; rsp_err[1] = p1.rsp_err;
        end
        if (MemWrite) begin
            mw_cnt++; mw_addr = Mem_Addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input bit v, input bit w,
                           input logic [63:0] a, input logic [63:0] d);
        if (port == 0) begin
            p0.req_valid = v; p0.req_write = w;
            p0.req_addr  = a; p0.req_wdata = d;
        end else begin
            p1.req_valid = v; p1.req_write = w;
            p1.req_addr  = a; p1.req_wdata = d;
        end
    endtask

    task automatic wait_acc(input int port);
        int n = 0;
        bit got;
        do begin
            tick();
            n++;
            got = (port == 1) ? acc1 : acc0;
        end while (!got && n < 50);
        if (!got) chk("acc_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_req(input int port, input bit w,
                          input logic [63:0] a, input logic [63:0] d,
                          output logic [63:0] rd, output bit er,
                          output int lat);
        int n0;
        int n = 0;
        set_req(port, 1, w, a, d);
        wait_acc(port);
        set_req(port, 0, 0, 0, 0);
        n0 = rsp_cnt[port];
        while (rsp_cnt[port] == n0 && n < 20) begin
            tick();
            n++;
        end
        if (rsp_cnt[port] == n0) begin
            chk("rsp_timeout", 64'd0, 64'd1);
            rd = 0; er = 0; lat = -1;
        end else begin
            rd  = rsp_data[port];
            er  = rsp_err[port];
            lat = rsp_cyc[port] - acc_cyc[port];
        end
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1:    return 64'($urandom_range(0, 7) * 8);
            2:       return 64'($urandom_range(0, 63));
            3:       return 64'd57;
            4:       return ($urandom_range(0, 1) == 1) ? 64'd64 : 64'h100;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    logic [63:0] rng_addr [4] = '{64'd56, 64'd57, 64'd64, 64'h100};
    bit          rng_err  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        logic [63:0] rd;
        bit          er;
        int          lat, mw0, r0, r1, a0, n;

        // Tie in the first IDLE cycle after reset, then strict alternation.
        set_req(0, 1, 0, 64'd8, 64'd0);
        set_req(1, 1, 0, 64'd0, 64'd0);
        repeat (3) tick();
        chk("rst_ready", 64'({p1.req_ready, p0.req_ready}), 64'd0);
        chk("rst_mem", 64'({MemWrite, MemRead}), 64'd0);
        chk("rst_rsp", 64'({p1.rsp_valid, p0.rsp_valid}), 64'd0);
        grant_log.delete();
        acc_log.delete();
        reset = 0;
        n = 0;
        while (grant_log.size() < 8 && n < 100) begin
            tick();
            n++;
            if (acc0) set_req(0, 1, 0, 64'($urandom_range(0, 7) * 8), 0);
            if (acc1) set_req(1, 1, 0, 64'($urandom_range(0, 7) * 8), 0);
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        chk("alt_count", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            chk("alt_port", 64'(grant_log[i]), 64'(i % 2));
            if (i > 0) chk("alt_gap", 64'(acc_log[i] - acc_log[i-1]), 64'd3);
        end
        repeat (4) tick();

        // Store then load on port 0.
        mw0 = mw_cnt;
        do_req(0, 1, 64'd8, 64'h1122334455667788, rd, er, lat);
        chk("st_mw_cnt", 64'(mw_cnt - mw0), 64'd1);
        chk("st_mw_addr", mw_addr, 64'd8);
        chk("st_err", 64'(er), 64'd0);
        chk("st_rdata", rd, 64'd0);
        chk("st_lat", 64'(lat), 64'd2);
        do_req(0, 0, 64'd8, 64'd0, rd, er, lat);
        chk("ld_rdata", rd, 64'h1122334455667788);
        chk("ld_err", 64'(er), 64'd0);
        chk("ld_lat", 64'(lat), 64'd2);

        // Misaligned store on port 1 leaves memory untouched.
        do_req(1, 1, 64'd0, 64'hA5A55A5A0F0FF0F0, rd, er, lat);
        mw0 = mw_cnt;
        do_req(1, 1, 64'd4, 64'hFFFFFFFFFFFFFFFF, rd, er, lat);
        chk("mis_err", 64'(er), 64'd1);
        chk("mis_rdata", rd, 64'd0);
        chk("mis_lat", 64'(lat), 64'd1);
        chk("mis_mw", 64'(mw_cnt - mw0), 64'd0);
        do_req(1, 0, 64'd0, 64'd0, rd, er, lat);
        chk("mis_keep", rd, 64'hA5A55A5A0F0FF0F0);

        // Range edges, including nonzero upper address bits.
        for (int i = 0; i < 4; i++) begin
            do_req(0, 0, rng_addr[i], 64'd0, rd, er, lat);
            chk("rng_err", 64'(er), 64'(rng_err[i]));
            chk("rng_lat", 64'(lat), rng_err[i] ? 64'd1 : 64'd2);
        end

        // Reset during the access cycle of a store aborts it.
        set_req(0, 1, 1, 64'd16, 64'hFFFFFFFFFFFFFFFF);
        wait_acc(0);
        set_req(0, 0, 0, 0, 0);
        mw0 = mw_cnt;
        r0  = rsp_cnt[0];
        reset = 1;
        tick();
        reset = 0;
        repeat (3) tick();
        chk("rst_acc_mw", 64'(mw_cnt - mw0), 64'd0);
        chk("rst_acc_rsp", 64'(rsp_cnt[0] - r0), 64'd0);
        do_req(0, 0, 64'd16, 64'd0, rd, er, lat);
        chk("rst_acc_ld", rd, 64'd0);

        // Port 0 withdraws its request while port 1 is busy.
        a0 = acc_cnt[0];
        r0 = rsp_cnt[0];
        r1 = rsp_cnt[1];
        set_req(1, 1, 0, 64'd8, 64'd0);
        wait_acc(1);
        set_req(1, 0, 0, 0, 0);
        set_req(0, 1, 1, 64'd24, 64'hDEADBEEF00000001);
        tick();
        set_req(0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("wd_acc0", 64'(acc_cnt[0] - a0), 64'd0);
        chk("wd_rsp0", 64'(rsp_cnt[0] - r0), 64'd0);
        chk("wd_rsp1", 64'(rsp_cnt[1] - r1), 64'd1);
        chk("wd_rdata1", rsp_data[1], 64'h1122334455667788);

        // Random traffic with occasional resets.
        for (int c = 0; c < 800; c++) begin
            tick();
            if (reset) reset = 0;
            else if ($urandom_range(0, 79) == 0) reset = 1;
            for (int p = 0; p < 2; p++) begin
                bit v;
                bit a;
                v = (p == 1) ? p1.req_valid : p0.req_valid;
                a = (p == 1) ? acc1 : acc0;
                if (v && !a) begin
                    if ($urandom_range(0, 15) == 0) set_req(p, 0, 0, 0, 0);
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(p, 1, 1'($urandom_range(0, 1)), rand_addr(),
                            {$urandom, $urandom});
                end else begin
                    set_req(p, 0, 0, 0, 0);
                end
            end
        end
        reset = 0;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
